// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Interrupt-entry sequencer that works alongside the control unit. It latches
// rising edges on up to NUM_SRC interrupt sources, picks a winner using a
// two-level priority (high beats low, lowest index wins within a level),
// stalls the control unit while it pushes the return PC (low byte, then high
// byte), and then loads the selected vector into the PC. In-service levels are
// tracked so that a high-priority request can preempt a low one; the control
// unit's second RETI pop clears the most recent level.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   irq_src     raw source lines, rising-edge sensitive
//   ie          bit7 = global enable, bits[NUM_SRC-1:0] = per-source enables
//   ip          per-source priority, 1 = high level
//   int_en      control unit is at an interruptible boundary
//   reti_pop    second RETI pop strobe from the control unit
//   pc_in       current PC (the return address)
//   int_stall   stall to the control unit ("int" is a reserved word)
//   stack_push  one-cycle push strobe
//   stack_data  byte to push
//   pc_set      one-cycle PC load strobe
//   pc_vector   vector address, valid while pc_set is high
//   pending     latched request flags
//   in_service  {high_active, low_active}
// ---------------------------------------------------------------------------
module interrupt_controller #(
   parameter int          NUM_SRC    = 5,
   parameter logic [15:0] VEC_BASE   = 16'h0003,
   parameter int          VEC_STRIDE = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [7:0]         ie,
   input  logic [NUM_SRC-1:0] ip,
   input  logic               int_en,
   input  logic               reti_pop,
   input  logic [15:0]        pc_in,
   output logic               int_stall,
   output logic               stack_push,
   output logic [7:0]         stack_data,
   output logic               pc_set,
   output logic [15:0]        pc_vector,
   output logic [NUM_SRC-1:0] pending,
   output logic [1:0]         in_service
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PUSH_L = 2'd1,
      PUSH_H = 2'd2,
      VECTOR = 2'd3
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clear_mask;
   logic [IDX_W-1:0]   idx;
   logic               lvl;
   logic [IDX_W-1:0]   hi_idx;
   logic [IDX_W-1:0]   lo_idx;
   logic               hi_found;
   logic               lo_found;
   logic [IDX_W-1:0]   win_idx;
   logic               win_lvl;
   logic               accept;
   logic               unused_ie;

   // Enable bits between the last source and the global enable are not used.
   assign unused_ie = ^ie[6:NUM_SRC];

   assign rise     = irq_src & ~prev;
   assign eligible = pending & ie[NUM_SRC-1:0] & {NUM_SRC{ie[7]}};

   // The bit being serviced is dropped as the sequence leaves VECTOR; a fresh
   // edge on the same line in that cycle is OR-ed back in so it is not lost.
   assign clear_mask = (state == VECTOR) ? (NUM_SRC'(1) << idx) : '0;

   // Priority search: scanning from the top index down lets the lowest
   // eligible index overwrite earlier hits, so it wins within each level.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i] && ip[i]) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(i);
         end
         if (eligible[i] && !ip[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDX_W'(i);
         end
      end
   end

   // A high winner masks every low source; it may only preempt a low level.
   // A low winner needs nothing in service. A RETI pop in the same cycle
   // takes precedence so the in-service update settles first.
   always_comb begin
      win_idx = hi_found ? hi_idx : lo_idx;
      win_lvl = hi_found;
      accept  = 1'b0;
      if (state == IDLE && int_en && !reti_pop) begin
         if (hi_found)
            accept = !in_service[1];
         else if (lo_found)
            accept = (in_service == 2'b00);
      end
   end

   // Edge history and request latching.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev    <= '0;
         pending <= '0;
      end else begin
         prev    <= irq_src;
         pending <= (pending & ~clear_mask) | rise;
      end
   end

   // In-service levels: set when a vector is issued, cleared by RETI pops
   // with the high level retired before the low one.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_service <= 2'b00;
      end else if (state == VECTOR) begin
         in_service[lvl] <= 1'b1;
      end else if (state == IDLE && reti_pop) begin
         if (in_service[1])
            in_service[1] <= 1'b0;
         else
            in_service[0] <= 1'b0;
      end
   end

   // Entry sequencer. Outputs are registered alongside the state so each
   // active state presents its own strobes; int_stall spans all three.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         lvl        <= 1'b0;
         int_stall  <= 1'b0;
         stack_push <= 1'b0;
         stack_data <= 8'h00;
         pc_set     <= 1'b0;
         pc_vector  <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= PUSH_L;
                  idx        <= win_idx;
                  lvl        <= win_lvl;
                  int_stall  <= 1'b1;
                  stack_push <= 1'b1;
                  stack_data <= pc_in[7:0];
               end
            end
            PUSH_L: begin
               state      <= PUSH_H;
               stack_push <= 1'b1;
               stack_data <= pc_in[15:8];
            end
            PUSH_H: begin
               state      <= VECTOR;
               stack_push <= 1'b0;
               stack_data <= 8'h00;
               pc_set     <= 1'b1;
               pc_vector  <= VEC_BASE + 16'(idx) * 16'(VEC_STRIDE);
            end
            VECTOR: begin
               state     <= IDLE;
               int_stall <= 1'b0;
               pc_set    <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller. Each scenario task drives
// stimulus, pushes the expected push/vector transaction to a scoreboard and
// does its own inline checks; a monitor pops the scoreboard whenever the DUT
// issues pc_set and compares the captured stack bytes and vector.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

   logic        clock;
   logic        reset;
   logic [4:0]  irq_src;
   logic [7:0]  ie;
   logic [4:0]  ip;
   logic        int_en;
   logic        reti_pop;
   logic [15:0] pc_in;
   logic        int_stall;
   logic        stack_push;
   logic [7:0]  stack_data;
   logic        pc_set;
   logic [15:0] pc_vector;
   logic [4:0]  pending;
   logic [1:0]  in_service;

   typedef struct {
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] vec;
   } exp_t;

   exp_t sb[$];
   int   assertions = 0;
   int   failures   = 0;

   interrupt_controller dut (
      .clock      (clock),
      .reset      (reset),
      .irq_src    (irq_src),
      .ie         (ie),
      .ip         (ip),
      .int_en     (int_en),
      .reti_pop   (reti_pop),
      .pc_in      (pc_in),
      .int_stall  (int_stall),
      .stack_push (stack_push),
      .stack_data (stack_data),
      .pc_set     (pc_set),
      .pc_vector  (pc_vector),
      .pending    (pending),
      .in_service (in_service)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: captures pushed bytes, checks the stall width on each falling
   // edge of int_stall, and pops the scoreboard on every pc_set.
   logic [7:0] cap [2];
   int         byte_cnt = 0;
   int         int_run  = 0;
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         byte_cnt = 0;
         int_run  = 0;
      end else begin
         if (stack_push) begin
            if (byte_cnt < 2) cap[byte_cnt] = stack_data;
            byte_cnt++;
         end
         if (int_stall) begin
            int_run++;
         end else if (int_run != 0) begin
            assertions++;
            if (int_run !== 3) begin
               failures++;
               $display("[TB] FAIL int_width: got %0d cycles, expected 3", int_run);
            end
            int_run = 0;
         end
         if (pc_set) begin
            assertions++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_pc_set: got vector %h, expected no pc_set", pc_vector);
            end else begin
               e = sb.pop_front();
               if (byte_cnt !== 2) begin
                  failures++;
                  $display("[TB] FAIL push_count: got %0d, expected 2", byte_cnt);
               end
               assertions++;
               if (cap[0] !== e.lo) begin
                  failures++;
                  $display("[TB] FAIL push_lo: got %h, expected %h", cap[0], e.lo);
               end
               assertions++;
               if (cap[1] !== e.hi) begin
                  failures++;
                  $display("[TB] FAIL push_hi: got %h, expected %h", cap[1], e.hi);
               end
               assertions++;
               if (pc_vector !== e.vec) begin
                  failures++;
                  $display("[TB] FAIL vector: got %h, expected %h", pc_vector, e.vec);
               end
            end
            byte_cnt = 0;
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Edge on the masked sources for one cycle; returns with pending latched.
   task automatic pulse_src(input logic [4:0] mask);
      irq_src = irq_src | mask;
      step(1);
      irq_src = irq_src & ~mask;
   endtask

   task automatic do_reti();
      reti_pop = 1'b1;
      step(1);
      reti_pop = 1'b0;
   endtask

   // Bounded wait for a complete entry sequence (int_stall rise then fall).
   task automatic wait_int_done(input string name);
      int n = 0;
      while (!int_stall && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!int_stall) begin
         assertions++;
         failures++;
         $display("[TB] FAIL %s_timeout_rise: got int 0, expected 1 within 20 cycles", name);
         return;
      end
      n = 0;
      while (int_stall && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (int_stall) begin
         assertions++;
         failures++;
         $display("[TB] FAIL %s_timeout_fall: got int 1, expected 0 within 20 cycles", name);
      end
      step(1);
   endtask

   task automatic check_quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step(1);
         assertions++;
         if (int_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got int %b, expected 0", name, int_stall);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      assertions++;
      if ({int_stall, stack_push, pc_set} !== 3'b000 || stack_data !== 8'h00 || pc_vector !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got int %b push %b set %b data %h vec %h, expected all 0",
                  int_stall, stack_push, pc_set, stack_data, pc_vector);
      end
      assertions++;
      if (pending !== 5'b0 || in_service !== 2'b00) begin
         failures++;
         $display("[TB] FAIL reset_state: got pending %b in_service %b, expected 0/00", pending, in_service);
      end
      reset = 1'b0;
      step(1);
   endtask

   // Single low source with the line held high afterwards.
   task automatic test_single_low();
      ie = 8'h81; ip = 5'b0; int_en = 1'b1; pc_in = 16'h1234;
      sb.push_back('{lo: 8'h34, hi: 8'h12, vec: 16'h0003});
      irq_src[0] = 1'b1;
      step(1);
      assertions++;
      if (pending !== 5'b00001 || int_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_latch: got pending %b int %b, expected 00001/0", pending, int_stall);
      end
      step(1);
      assertions++;
      if (int_stall !== 1'b1 || stack_push !== 1'b1 || stack_data !== 8'h34) begin
         failures++;
         $display("[TB] FAIL single_push_l: got int %b push %b data %h, expected 1/1/34", int_stall, stack_push, stack_data);
      end
      wait_int_done("single");
      assertions++;
      if (in_service !== 2'b01 || pending !== 5'b0) begin
         failures++;
         $display("[TB] FAIL single_after: got in_service %b pending %b, expected 01/00000", in_service, pending);
      end
      check_quiet("single_level_held", 3);
      irq_src = 5'b0;
      do_reti();
      assertions++;
      if (in_service !== 2'b00) begin
         failures++;
         $display("[TB] FAIL single_reti: got %b, expected 00", in_service);
      end
   endtask

   task automatic test_priority();
      ie = 8'h8A; ip = 5'b01000; pc_in = 16'h5678;
      sb.push_back('{lo: 8'h78, hi: 8'h56, vec: 16'h001B});
      sb.push_back('{lo: 8'h78, hi: 8'h56, vec: 16'h000B});
      pulse_src(5'b01010);
      wait_int_done("prio_first");
      assertions++;
      if (in_service !== 2'b10 || pending !== 5'b00010) begin
         failures++;
         $display("[TB] FAIL prio_first_state: got in_service %b pending %b, expected 10/00010", in_service, pending);
      end
      check_quiet("prio_blocked", 3);
      do_reti();
      wait_int_done("prio_second");
      assertions++;
      if (in_service !== 2'b01 || pending !== 5'b0) begin
         failures++;
         $display("[TB] FAIL prio_second_state: got in_service %b pending %b, expected 01/00000", in_service, pending);
      end
      do_reti();
   endtask

   task automatic test_nesting();
      ie = 8'h91; ip = 5'b10000; pc_in = 16'h0100;
      sb.push_back('{lo: 8'h00, hi: 8'h01, vec: 16'h0003});
      pulse_src(5'b00001);
      wait_int_done("nest_low");
      pc_in = 16'hABCD;
      sb.push_back('{lo: 8'hCD, hi: 8'hAB, vec: 16'h0023});
      pulse_src(5'b10000);
      wait_int_done("nest_high");
      assertions++;
      if (in_service !== 2'b11) begin
         failures++;
         $display("[TB] FAIL nest_both: got %b, expected 11", in_service);
      end
      do_reti();
      assertions++;
      if (in_service !== 2'b01) begin
         failures++;
         $display("[TB] FAIL nest_reti1: got %b, expected 01", in_service);
      end
      do_reti();
      assertions++;
      if (in_service !== 2'b00) begin
         failures++;
         $display("[TB] FAIL nest_reti2: got %b, expected 00", in_service);
      end
   endtask

   task automatic test_blocking();
      ie = 8'h85; ip = 5'b0; pc_in = 16'h2200;
      sb.push_back('{lo: 8'h00, hi: 8'h22, vec: 16'h0003});
      pulse_src(5'b00001);
      wait_int_done("block_first");
      pulse_src(5'b00100);
      check_quiet("block_low_in_service", 5);
      ie = 8'h05;
      do_reti();
      check_quiet("block_ea_off", 5);
      assertions++;
      if (pending !== 5'b00100 || in_service !== 2'b00) begin
         failures++;
         $display("[TB] FAIL block_pending: got pending %b in_service %b, expected 00100/00", pending, in_service);
      end
      pc_in = 16'h3344;
      sb.push_back('{lo: 8'h44, hi: 8'h33, vec: 16'h0013});
      ie = 8'h85;
      wait_int_done("block_release");
      assertions++;
      if (in_service !== 2'b01 || pending !== 5'b0) begin
         failures++;
         $display("[TB] FAIL block_release_state: got in_service %b pending %b, expected 01/00000", in_service, pending);
      end
      do_reti();
   endtask

   task automatic test_gating();
      ie = 8'h81; ip = 5'b0; pc_in = 16'h4455; int_en = 1'b0;
      sb.push_back('{lo: 8'h55, hi: 8'h44, vec: 16'h0003});
      pulse_src(5'b00001);
      check_quiet("gate_int_en_low", 4);
      int_en = 1'b1;
      step(1);
      assertions++;
      if (int_stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL gate_release: got int %b, expected 1", int_stall);
      end
      wait_int_done("gate");
      do_reti();
      // reti_pop coincides with the first eligible cycle
      sb.push_back('{lo: 8'h55, hi: 8'h44, vec: 16'h0003});
      pulse_src(5'b00001);
      reti_pop = 1'b1;
      step(1);
      reti_pop = 1'b0;
      assertions++;
      if (int_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL gate_reti_block: got int %b, expected 0", int_stall);
      end
      step(1);
      assertions++;
      if (int_stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL gate_reti_delay: got int %b, expected 1", int_stall);
      end
      wait_int_done("gate_reti");
      do_reti();
   endtask

   task automatic test_reset_mid();
      ie = 8'h81; ip = 5'b0; pc_in = 16'h6677;
      pulse_src(5'b00001);
      step(1);
      assertions++;
      if (int_stall !== 1'b1 || stack_data !== 8'h77) begin
         failures++;
         $display("[TB] FAIL rmid_push_l: got int %b data %h, expected 1/77", int_stall, stack_data);
      end
      step(1);
      assertions++;
      if (stack_push !== 1'b1 || stack_data !== 8'h66) begin
         failures++;
         $display("[TB] FAIL rmid_push_h: got push %b data %h, expected 1/66", stack_push, stack_data);
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      assertions++;
      if ({int_stall, stack_push, pc_set} !== 3'b000 || pending !== 5'b0 || in_service !== 2'b00) begin
         failures++;
         $display("[TB] FAIL rmid_state: got int %b push %b set %b pending %b ins %b, expected all 0",
                  int_stall, stack_push, pc_set, pending, in_service);
      end
      check_quiet("rmid_idle", 5);
   endtask

   initial begin
      reset = 1'b1; irq_src = 5'b0; ie = 8'h00; ip = 5'b0;
      int_en = 1'b0; reti_pop = 1'b0; pc_in = 16'h0000;
      test_reset();
      test_single_low();
      test_priority();
      test_nesting();
      test_blocking();
      test_gating();
      test_reset_mid();
      assertions++;
      if (sb.size() !== 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d outstanding, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Interrupt-entry sequencer paired with the control unit, which already handles interrupt exit (RETI pops).
- Latches up to five interrupt sources and arbitrates them by two-level priority plus a fixed order.
- Holds the control unit stalled via `int` while it pushes the return PC onto the stack (low byte, then high byte) and loads the vector into the PC.
- Tracks in-service levels so a high-priority interrupt can preempt a low one; RETI pops clear the in-service level.

Parameters:
- NUM_SRC, 5, number of interrupt sources (bit0 IE0, bit1 TF0, bit2 IE1, bit3 TF1, bit4 serial).
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, vector spacing in bytes: vector = VEC_BASE + idx*VEC_STRIDE.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- irq_src  in  NUM_SRC  raw source lines; rising-edge sensitive.
- ie  in  8  enable register; bit7 = EA (global enable), bits[NUM_SRC-1:0] = per-source enables.
- ip  in  NUM_SRC  priority bits; 1 = high level, 0 = low level.
- int_en  in  1  control unit at an interruptible boundary.
- reti_pop  in  1  control-unit second RETI pop pulse (pop_2_stack).
- pc_in  in  16  current PC, i.e. the return address.
- int  out  1  stall to the control unit.
- stack_push  out  1  one-cycle push strobe.
- stack_data  out  8  byte to push.
- pc_set  out  1  one-cycle PC load strobe.
- pc_vector  out  16  vector address; valid while pc_set = 1.
- pending  out  NUM_SRC  latched request flags.
- in_service  out  2  {high_active, low_active}.

Behaviour:
- Reset (synchronous, any state, including mid-sequence):
  - state = IDLE; pending, in_service, edge-detect history all 0.
  - int, stack_push, pc_set = 0; stack_data = 0; pc_vector = 0.
- Edge detect:
  - irq_src is registered into prev each cycle.
  - pending[i] is set the cycle after irq_src[i] & ~prev[i].
  - Level-held lines set pending only once per edge.
- Eligible source i: pending[i] & ie[i] & ie[7].
- Arbitration in IDLE, combinational:
  - Any eligible high-level source beats any low-level source.
  - Within a level, the lowest index wins.
  - Winner level L is accepted only if int_en=1, reti_pop=0, and:
    - L=high: in_service[1]=0.
    - L=low: in_service==2'b00.
  - On acceptance, register idx and L, and go to PUSH_L.
- FSM: IDLE -> PUSH_L -> PUSH_H -> VECTOR -> IDLE. The three active states are one cycle each.
  - PUSH_L: int=1, stack_push=1, stack_data=pc_in[7:0].
  - PUSH_H: int=1, stack_push=1, stack_data=pc_in[15:8].
  - VECTOR: int=1, pc_set=1, pc_vector = VEC_BASE + idx*VEC_STRIDE (16-bit, no overflow for defaults); clear pending[idx]; set in_service[L].
  - int is registered and high exactly 3 cycles per entry. Latency from the first eligible cycle to int rising is 1 cycle.
  - pc_in must stay stable while int=1; the stall guarantees this.
- Simultaneous events:
  - A new edge on idx in the same cycle as its VECTOR clear: set wins, pending stays 1.
  - reti_pop in IDLE: clears in_service[1] if set, else in_service[0]. No acceptance that cycle.
  - reti_pop with in_service==0: ignored.
  - ie/ip changes while in PUSH_L..VECTOR: do not affect the latched idx.
  - Sources that become pending during a sequence are arbitrated on return to IDLE.
- Masked (ie bit 0) sources keep pending set until enabled and serviced.

Test Plan:
- Single low source: ie=8'h81, ip=0, edge on irq_src[0], int_en=1, pc_in=16'h1234 -> pushes 8'h34 then 8'h12; pc_set with pc_vector=16'h0003; int high 3 cycles; in_service=2'b01; pending[0]=0.
- Priority order: edges on src1 and src3 in the same cycle, ip=5'b01000, ie=8'h8A -> src3 serviced first (vector 16'h001B). After its reti_pop, src1 is serviced (16'h000B).
- Nesting: src0 low in service; edge on src4 with ip[4]=1, ie=8'h91 -> accepted, vector 16'h0023, in_service=2'b11. First reti_pop -> 2'b01, second -> 2'b00.
- Blocking: in_service=2'b01 and a new low edge on src2 -> no int. Same with EA=0 -> pending[2]=1, no int. Set EA and clear in_service -> serviced at 16'h0013.
- Boundary gating: edge with int_en=0 for 4 cycles -> int stays 0; int_en rises -> int asserted next cycle. reti_pop in the same cycle as eligibility -> acceptance delayed 1 cycle.
- Reset during PUSH_H -> next cycle int=0, stack_push=0, pending=0, in_service=0, state IDLE; no pc_set ever issued.
